// File: rtl/apb_spi_master_fifo.sv
// apb_spi_master_fifo
//   APB slave SPI master with TX/RX FIFOs, multi-frame bursts under one slave
//   select, all four SPI modes and sticky overflow flags.
//   Optional macro SPI_MASTER_IRQ_EN adds o_IRQ and the IRQ_MASK register at 0x2.
// Ports:
//   i_PCLK, i_PRESETn        clock, synchronous active-low reset
//   i_PSEL..i_PWDATA         APB request; i_BASE_ADDR matched against i_PADDR[15:6]
//   o_PRDATA, o_PREADY       APB response (combinational read data, no wait states)
//   o_SCK, o_MOSI, i_MISO    SPI bus, MSB first
//   o_SS                     active-low slave selects
//   o_IRQ                    registered interrupt (only with SPI_MASTER_IRQ_EN)
module apb_spi_master_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_SS     = 4
) (
  input  logic              i_PCLK,
  input  logic              i_PRESETn,
  input  logic              i_PSEL,
  input  logic              i_PENABLE,
  input  logic              i_PWRITE,
  input  logic [15:0]       i_PADDR,
  input  logic [DATA_W-1:0] i_PWDATA,
  input  logic [9:0]        i_BASE_ADDR,
  output logic [DATA_W-1:0] o_PRDATA,
  output logic              o_PREADY,
  output logic              o_SCK,
  output logic              o_MOSI,
  input  logic              i_MISO,
  output logic [NUM_SS-1:0] o_SS
`ifdef SPI_MASTER_IRQ_EN
  ,
  output logic              o_IRQ
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = $clog2(2 * DATA_W);

  typedef enum logic [1:0] {IDLE, LEAD, XFER, GAP} state_t;

  state_t            state_q, state_d;
  logic [5:0]        cfg_q, cfg_d, shd_q, shd_d;
  logic [DATA_W-1:0] tx_mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] tx_mem_d [FIFO_DEPTH];
  logic [DATA_W-1:0] rx_mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] rx_mem_d [FIFO_DEPTH];
  logic [AW:0]       tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [AW:0]       rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic              tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
  logic [3:0]        div_cnt_q, div_cnt_d;
  logic [EW-1:0]     edge_q, edge_d;
  logic [DATA_W-1:0] tsh_q, tsh_d, rsh_q, rsh_d;
  logic              sck_q, sck_d, mosi_q, mosi_d;

  // APB decode; accesses act only in the enable phase
  logic       acc, wr, rd;
  logic [3:0] off;
  assign acc = i_PSEL && (i_PADDR[15:6] == i_BASE_ADDR) && i_PENABLE;
  assign wr  = acc && i_PWRITE;
  assign rd  = acc && !i_PWRITE;
  assign off = i_PADDR[5:2];

  logic busy, tx_empty, tx_full, rx_empty, rx_full;
  assign busy     = (state_q != IDLE);
  assign tx_empty = (tx_wp_q == tx_rp_q);
  assign rx_empty = (rx_wp_q == rx_rp_q);
  assign tx_full  = (tx_wp_q[AW] != tx_rp_q[AW]) && (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]);
  assign rx_full  = (rx_wp_q[AW] != rx_rp_q[AW]) && (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]);

  logic [DATA_W-1:0] tx_head, rx_head;
  assign tx_head = tx_mem_q[tx_rp_q[AW-1:0]];
  assign rx_head = rx_mem_q[rx_rp_q[AW-1:0]];

  logic cmd_start, cmd_flush, flush, status_rd;
  assign cmd_start = wr && (off == 4'd3) && i_PWDATA[1];
  assign cmd_flush = wr && (off == 4'd3) && i_PWDATA[0];
  assign flush     = cmd_flush && !busy;
  assign status_rd = rd && (off == 4'd0);

  // While busy all timing comes from the shadow, so CONFIG writes mid-burst
  // only land on the next START.
  logic half_last;
  assign half_last = (div_cnt_q == ((4'd1 << shd_q[1:0]) - 4'd1));

  logic              tx_pop, rx_push, enter_lead, done_evt;
  logic [DATA_W-1:0] rx_frame;

  always_comb begin
    state_d    = state_q;
    shd_d      = shd_q;
    div_cnt_d  = div_cnt_q;
    edge_d     = edge_q;
    tsh_d      = tsh_q;
    rsh_d      = rsh_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    tx_pop     = 1'b0;
    rx_push    = 1'b0;
    rx_frame   = '0;
    enter_lead = 1'b0;
    done_evt   = 1'b0;
    case (state_q)
      IDLE: begin
        sck_d = cfg_q[5];
        if (cmd_start && !cmd_flush && !tx_empty) begin
          shd_d      = cfg_q;
          enter_lead = 1'b1;
        end
      end
      LEAD: begin
        div_cnt_d = div_cnt_q + 4'd1;
        if (half_last) begin
          div_cnt_d = '0;
          edge_d    = '0;
          state_d   = XFER;
        end
      end
      XFER: begin
        div_cnt_d = div_cnt_q + 4'd1;
        if (half_last) begin
          div_cnt_d = '0;
          sck_d     = ~sck_q;
          edge_d    = edge_q + 1'b1;
          // even edge index = leading edge; sample when leading XOR CPHA
          if (!edge_q[0] ^ shd_q[4]) begin
            rsh_d = {rsh_q[DATA_W-2:0], i_MISO};
          end else begin
            mosi_d = shd_q[4] ? tsh_q[DATA_W-1] : tsh_q[DATA_W-2];
            tsh_d  = tsh_q << 1;
          end
          if (edge_q == EW'(2 * DATA_W - 1)) begin
            rx_push  = 1'b1;
            rx_frame = rsh_d;
            edge_d   = '0;
            state_d  = GAP;
          end
        end
      end
      GAP: begin
        div_cnt_d = div_cnt_q + 4'd1;
        if (half_last) begin
          div_cnt_d = '0;
          if (!tx_empty) begin
            enter_lead = 1'b1;
          end else begin
            state_d  = IDLE;
            done_evt = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Frame load is shared by START and burst continuation out of GAP.
    if (enter_lead) begin
      state_d   = LEAD;
      div_cnt_d = '0;
      tx_pop    = 1'b1;
      tsh_d     = tx_head;
      sck_d     = shd_d[5];
      if (!shd_d[4]) mosi_d = tx_head[DATA_W-1];
    end
  end

  // FIFO bookkeeping; a same-cycle pop frees the slot a full-FIFO push needs
  logic tx_push_req, tx_push, rx_pop, rx_push_ok;
  assign tx_push_req = wr && (off == 4'd1);
  assign tx_push     = tx_push_req && (!tx_full || tx_pop);
  assign rx_pop      = rd && (off == 4'd1) && !rx_empty;
  assign rx_push_ok  = rx_push && (!rx_full || rx_pop);

  always_comb begin
    tx_mem_d = tx_mem_q;
    rx_mem_d = rx_mem_q;
    if (tx_push)    tx_mem_d[tx_wp_q[AW-1:0]] = i_PWDATA;
    if (rx_push_ok) rx_mem_d[rx_wp_q[AW-1:0]] = rx_frame;
    tx_wp_d  = tx_wp_q + {{AW{1'b0}}, tx_push};
    tx_rp_d  = tx_rp_q + {{AW{1'b0}}, tx_pop};
    rx_wp_d  = rx_wp_q + {{AW{1'b0}}, rx_push_ok};
    rx_rp_d  = rx_rp_q + {{AW{1'b0}}, rx_pop};
    tx_ovf_d = tx_ovf_q;
    rx_ovf_d = rx_ovf_q;
    if (status_rd || flush) begin
      tx_ovf_d = 1'b0;
      rx_ovf_d = 1'b0;
    end
    // a new overflow in the reading cycle survives the clear
    if (tx_push_req && tx_full && !tx_pop) tx_ovf_d = 1'b1;
    if (rx_push && rx_full && !rx_pop)     rx_ovf_d = 1'b1;
    if (flush) begin
      tx_wp_d = '0;
      tx_rp_d = '0;
      rx_wp_d = '0;
      rx_rp_d = '0;
    end
    cfg_d = cfg_q;
    if (wr && (off == 4'd0)) cfg_d = i_PWDATA[5:0];
  end

`ifdef SPI_MASTER_IRQ_EN
  logic [2:0] irq_mask_q, irq_mask_d;
  logic       done_q, done_d, irq_q, irq_d;
  always_comb begin
    irq_mask_d = irq_mask_q;
    if (wr && (off == 4'd2)) irq_mask_d = i_PWDATA[2:0];
    done_d = done_q;
    if (status_rd) done_d = 1'b0;
    if (done_evt)  done_d = 1'b1;
    irq_d = |(irq_mask_q & {tx_ovf_q | rx_ovf_q, !rx_empty, done_q});
  end
  always_ff @(posedge i_PCLK) begin
    if (!i_PRESETn) begin
      irq_mask_q <= '0;
      done_q     <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      irq_mask_q <= irq_mask_d;
      done_q     <= done_d;
      irq_q      <= irq_d;
    end
  end
  assign o_IRQ = irq_q;
  logic unused_ok;
  assign unused_ok = ^i_PADDR[1:0];
`else
  logic unused_ok;
  assign unused_ok = ^{i_PADDR[1:0], done_evt};
`endif

  logic [7:0] status;
  assign status = {1'b0, rx_ovf_q, tx_ovf_q, rx_full, rx_empty, tx_full, tx_empty, busy};

  always_comb begin
    o_PRDATA = '0;
    if (rd) begin
      case (off)
        4'd0: o_PRDATA = DATA_W'(status);
        4'd1: o_PRDATA = rx_empty ? '0 : rx_head;
`ifdef SPI_MASTER_IRQ_EN
        4'd2: o_PRDATA = DATA_W'(irq_mask_q);
`endif
        default: o_PRDATA = '0;
      endcase
    end
  end

  always_comb begin
    o_SS = '1;
    for (int i = 0; i < NUM_SS; i++)
      if (busy && (shd_q[3:2] == i[1:0])) o_SS[i] = 1'b0;
  end

  assign o_PREADY = 1'b1;
  assign o_SCK    = sck_q;
  assign o_MOSI   = mosi_q;

  always_ff @(posedge i_PCLK) begin
    if (!i_PRESETn) begin
      state_q   <= IDLE;
      cfg_q     <= '0;
      shd_q     <= '0;
      tx_wp_q   <= '0;
      tx_rp_q   <= '0;
      rx_wp_q   <= '0;
      rx_rp_q   <= '0;
      tx_ovf_q  <= 1'b0;
      rx_ovf_q  <= 1'b0;
      div_cnt_q <= '0;
      edge_q    <= '0;
      tsh_q     <= '0;
      rsh_q     <= '0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      shd_q     <= shd_d;
      tx_wp_q   <= tx_wp_d;
      tx_rp_q   <= tx_rp_d;
      rx_wp_q   <= rx_wp_d;
      rx_rp_q   <= rx_rp_d;
      tx_ovf_q  <= tx_ovf_d;
      rx_ovf_q  <= rx_ovf_d;
      div_cnt_q <= div_cnt_d;
      edge_q    <= edge_d;
      tsh_q     <= tsh_d;
      rsh_q     <= rsh_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
    end
  end

  // storage carries no reset; pointers alone define the contents
  always_ff @(posedge i_PCLK) begin
    tx_mem_q <= tx_mem_d;
    rx_mem_q <= rx_mem_d;
  end

endmodule
